// File: rtl/wb_flash_arbiter_if.sv
// Bus bundle between the two Wishbone masters, the arbiter and the SPI flash controller.
// "slave" is the arbiter's view; "master" is the environment's view (masters plus flash controller).
interface wb_flash_arbiter_if;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i;
  logic [1:0]  o_grant;
  logic        o_timeout;

  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    input  s_dat_i, s_ack_i,
    output m0_dat_o, m0_ack_o, m0_err_o,
    output m1_dat_o, m1_ack_o, m1_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    output o_grant, o_timeout
  );

  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i,
    output s_dat_i, s_ack_i,
    input  m0_dat_o, m0_ack_o, m0_err_o,
    input  m1_dat_o, m1_ack_o, m1_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
    input  o_grant, o_timeout
  );
endinterface

// File: rtl/wb_flash_arbiter.sv
// Round-robin two-master Wishbone classic arbiter in front of the SPI flash controller,
// with a watchdog that aborts strobes the slave never acknowledges.
module wb_flash_arbiter #(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_flash_arbiter_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, GNT0, GNT1, ABORT, DRAIN} state_t;

  localparam bit          WD_EN    = (TIMEOUT != 0);
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        last_reg, last_next;
  logic        owner_reg, owner_next;
  logic [15:0] wd_cnt_reg, wd_cnt_next;

  logic [1:0]  m_cyc, m_stb, m_we, m_ack, m_err;
  logic [31:0] m_adr [2];
  logic [31:0] m_wdat [2];
  logic [31:0] m_rdat [2];
  logic        granted;

  assign m_cyc     = {bus.m1_cyc_i, bus.m0_cyc_i};
  assign m_stb     = {bus.m1_stb_i, bus.m0_stb_i};
  assign m_we      = {bus.m1_we_i,  bus.m0_we_i};
  assign m_adr[0]  = bus.m0_adr_i;
  assign m_adr[1]  = bus.m1_adr_i;
  assign m_wdat[0] = bus.m0_dat_i;
  assign m_wdat[1] = bus.m1_dat_i;

  // owner_reg names the master of the current GNT/ABORT/DRAIN episode
  assign granted = (state_reg == GNT0) || (state_reg == GNT1);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg  <= IDLE;
      last_reg   <= 1'b1;
      owner_reg  <= 1'b0;
      wd_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      owner_reg  <= owner_next;
      wd_cnt_reg <= wd_cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    last_next   = last_reg;
    owner_next  = owner_reg;
    wd_cnt_next = '0;
    case (state_reg)
      IDLE: begin
        if (m_cyc[0] && m_cyc[1]) begin
          owner_next = ~last_reg;
          state_next = last_reg ? GNT0 : GNT1;
        end else if (m_cyc[0]) begin
          owner_next = 1'b0;
          state_next = GNT0;
        end else if (m_cyc[1]) begin
          owner_next = 1'b1;
          state_next = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!m_cyc[owner_reg]) begin
          state_next = IDLE;
          last_next  = owner_reg;
        end else if (m_stb[owner_reg] && !bus.s_ack_i) begin
          // an ack on the limit cycle wins, so only an unacked strobe can trip the watchdog
          if (WD_EN && (wd_cnt_reg == WD_LIMIT)) begin
            state_next = ABORT;
          end else begin
            wd_cnt_next = wd_cnt_reg + 16'd1;
          end
        end
      end
      ABORT: begin
        state_next = DRAIN;
      end
      DRAIN: begin
        if (!m_cyc[owner_reg]) begin
          state_next = IDLE;
          last_next  = owner_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.s_cyc_o   = granted & m_cyc[owner_reg];
  assign bus.s_stb_o   = granted & m_stb[owner_reg];
  assign bus.s_we_o    = granted & m_we[owner_reg];
  assign bus.s_adr_o   = granted ? m_adr[owner_reg]  : '0;
  assign bus.s_dat_o   = granted ? m_wdat[owner_reg] : '0;
  assign bus.o_timeout = (state_reg == ABORT);
  assign bus.o_grant   = (state_reg == IDLE) ? 2'b00 : (owner_reg ? 2'b10 : 2'b01);

  // responses reach only the master that owns the bus; slave acks outside GNT are dropped
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    assign m_ack[gi]  = granted && (owner_reg == 1'(gi)) && bus.s_ack_i;
    assign m_err[gi]  = (state_reg == ABORT) && (owner_reg == 1'(gi));
    assign m_rdat[gi] = (granted && (owner_reg == 1'(gi))) ? bus.s_dat_i : '0;
  end

  assign bus.m0_ack_o = m_ack[0];
  assign bus.m1_ack_o = m_ack[1];
  assign bus.m0_err_o = m_err[0];
  assign bus.m1_err_o = m_err[1];
  assign bus.m0_dat_o = m_rdat[0];
  assign bus.m1_dat_o = m_rdat[1];

endmodule

// File: tb/tb_wb_flash_arbiter.sv
// Bench for wb_flash_arbiter: directed scenarios plus randomized multi-beat traffic
// checked against a transaction-level round-robin model.
module tb_wb_flash_arbiter;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;
  always #5 wb_clk_i = ~wb_clk_i;

  wb_flash_arbiter_if i8();
  wb_flash_arbiter_if i4();

  wb_flash_arbiter #(.TIMEOUT(8)) dut8 (.wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .bus(i8.slave));
  wb_flash_arbiter #(.TIMEOUT(4)) dut4 (.wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .bus(i4.slave));

  int          n_vec = 0;
  int          n_err = 0;
  logic        last_m, own, re, we;
  logic [1:0]  pend;
  logic [31:0] adr_m [2];
  logic [31:0] adr, wdat, rdat;
  int          w, beats, d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drive(input int idx, input logic cyc, input logic stb, input logic we_v,
                       input logic [31:0] a, input logic [31:0] dt);
    if (idx == 0) begin
      i8.m0_cyc_i = cyc; i8.m0_stb_i = stb; i8.m0_we_i = we_v; i8.m0_adr_i = a; i8.m0_dat_i = dt;
    end else begin
      i8.m1_cyc_i = cyc; i8.m1_stb_i = stb; i8.m1_we_i = we_v; i8.m1_adr_i = a; i8.m1_dat_i = dt;
    end
  endtask

  function automatic logic ack_of(input logic idx);
    return idx ? i8.m1_ack_o : i8.m0_ack_o;
  endfunction

  function automatic logic [31:0] dat_of(input logic idx);
    return idx ? i8.m1_dat_o : i8.m0_dat_o;
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    i8.s_ack_i = 0; i8.s_dat_i = 0;
    i4.m0_cyc_i = 0; i4.m0_stb_i = 0; i4.m0_we_i = 0; i4.m0_adr_i = 0; i4.m0_dat_i = 0;
    i4.m1_cyc_i = 0; i4.m1_stb_i = 0; i4.m1_we_i = 0; i4.m1_adr_i = 0; i4.m1_dat_i = 0;
    i4.s_ack_i = 0; i4.s_dat_i = 0;

    // reset state
    wb_rst_i = 1;
    tick();
    check("rst_s_cyc", i8.s_cyc_o, 0);
    check("rst_grant", i8.o_grant, 0);
    check("rst_timeout", i8.o_timeout, 0);
    check("rst_m0_err", i8.m0_err_o, 0);
    check("rst_m1_ack", i8.m1_ack_o, 0);
    wb_rst_i = 0;

    // single master read, slave acks in the third granted cycle
    drive(0, 1, 1, 0, 32'h10, 0);
    tick();
    check("single_grant", i8.o_grant, 2'b01);
    check("single_s_cyc", i8.s_cyc_o, 1);
    check("single_s_adr", i8.s_adr_o, 32'h10);
    for (int i = 0; i < 2; i++) begin
      check("single_noack", i8.m0_ack_o, 0);
      tick();
    end
    i8.s_ack_i = 1; i8.s_dat_i = 32'hDEADBEEF;
    #1;
    check("single_ack", i8.m0_ack_o, 1);
    check("single_dat", i8.m0_dat_o, 32'hDEADBEEF);
    check("single_m1_ack", i8.m1_ack_o, 0);
    check("single_m1_dat", i8.m1_dat_o, 0);
    check("single_m1_err", i8.m1_err_o, 0);
    tick();
    i8.s_ack_i = 0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("single_release", i8.o_grant, 0);

    // contention right after reset: master 0 first, master 1 two cycles after release
    wb_rst_i = 1; tick(); wb_rst_i = 0;
    drive(0, 1, 1, 0, 32'hA0, 0);
    drive(1, 1, 1, 0, 32'hB0, 0);
    tick();
    check("cont_grant0", i8.o_grant, 2'b01);
    check("cont_adr0", i8.s_adr_o, 32'hA0);
    i8.s_ack_i = 1; i8.s_dat_i = 32'h1234;
    #1;
    check("cont_m1_held", i8.m1_ack_o, 0);
    tick();
    i8.s_ack_i = 0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("cont_gap", i8.o_grant, 2'b00);
    check("cont_gap_cyc", i8.s_cyc_o, 0);
    tick();
    check("cont_grant1", i8.o_grant, 2'b10);
    check("cont_adr1", i8.s_adr_o, 32'hB0);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    tick();

    // randomized traffic against a round-robin model; first 6 rounds keep both masters busy
    wb_rst_i = 1; tick(); wb_rst_i = 0;
    last_m = 1'b1;
    pend = 2'b11;
    for (int k = 0; k < 2; k++) begin
      adr_m[k] = $urandom;
      drive(k, 1, 1, 0, adr_m[k], 0);
    end
    tick();
    for (int t = 0; t < 16; t++) begin
      w = 0;
      while (i8.o_grant == 2'b00 && w < 4) begin
        tick();
        w++;
      end
      check("grant_seen", {31'b0, |i8.o_grant}, 1);
      own = (pend == 2'b11) ? ~last_m : pend[1];
      check("rr_grant", i8.o_grant, own ? 2'b10 : 2'b01);
      beats = $urandom_range(1, 3);
      for (int b = 0; b < beats; b++) begin
        adr = $urandom; wdat = $urandom; we = 1'($urandom_range(0, 1));
        adr_m[own] = adr;
        drive(int'(own), 1, 1, we, adr, wdat);
        d = $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
          i8.s_ack_i = 0;
          #1;
          check("rr_adr", i8.s_adr_o, adr);
          check("rr_wait_ack", ack_of(own), 0);
          tick();
        end
        rdat = $urandom;
        i8.s_ack_i = 1; i8.s_dat_i = rdat;
        #1;
        check("rr_ack", ack_of(own), 1);
        check("rr_rdat", dat_of(own), rdat);
        check("rr_we", i8.s_we_o, we);
        check("rr_wdat", i8.s_dat_o, wdat);
        check("rr_other_ack", ack_of(~own), 0);
        check("rr_other_dat", dat_of(~own), 0);
        tick();
        i8.s_ack_i = 0;
      end
      $display("txn %0d: master %0d served, %0d beats, grant=%b", t, own, beats, i8.o_grant);
      drive(int'(own), 0, 0, 0, 0, 0);
      pend[own] = 1'b0;
      last_m = own;
      tick();
      check("rr_gap", i8.o_grant, 0);
      if (t == 15) begin
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        pend = 2'b00;
      end else begin
        re = (t < 5 || !pend[~own]) ? 1'b1 : 1'($urandom_range(0, 1));
        if (re) begin
          adr_m[own] = $urandom;
          drive(int'(own), 1, 1, 0, adr_m[own], 0);
          pend[own] = 1'b1;
        end
      end
      tick();
    end
    check("rr_end_idle", i8.o_grant, 0);

    // watchdog with TIMEOUT = 8 on master 1
    drive(1, 1, 1, 0, 32'h77, 0);
    tick();
    check("to_grant", i8.o_grant, 2'b10);
    for (int c = 1; c <= 8; c++) begin
      check("to_no_err", i8.m1_err_o, 0);
      check("to_no_pulse", i8.o_timeout, 0);
      check("to_s_cyc", i8.s_cyc_o, 1);
      tick();
    end
    drive(0, 1, 1, 0, 32'h55, 0);
    i8.s_ack_i = 1; i8.s_dat_i = 32'hCAFE;
    #1;
    check("to_err", i8.m1_err_o, 1);
    check("to_pulse", i8.o_timeout, 1);
    check("to_abort_cyc", i8.s_cyc_o, 0);
    check("to_abort_stb", i8.s_stb_o, 0);
    check("to_late_ack", i8.m1_ack_o, 0);
    check("to_abort_grant", i8.o_grant, 2'b10);
    tick();
    check("to_drain_err", i8.m1_err_o, 0);
    check("to_drain_pulse", i8.o_timeout, 0);
    check("to_drain_cyc", i8.s_cyc_o, 0);
    check("to_drain_ack", i8.m1_ack_o, 0);
    check("to_drain_dat", i8.m1_dat_o, 0);
    drive(1, 0, 0, 0, 0, 0);
    i8.s_ack_i = 0;
    tick();
    check("to_idle", i8.o_grant, 0);
    tick();
    check("to_m0_grant", i8.o_grant, 2'b01);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // ack on the watchdog limit cycle with TIMEOUT = 4
    i4.m0_cyc_i = 1; i4.m0_stb_i = 1; i4.m0_adr_i = 32'h40;
    tick();
    for (int c = 1; c <= 3; c++) begin
      check("lim_no_err", i4.m0_err_o, 0);
      tick();
    end
    i4.s_ack_i = 1; i4.s_dat_i = 32'h600DF00D;
    #1;
    check("lim_ack", i4.m0_ack_o, 1);
    check("lim_dat", i4.m0_dat_o, 32'h600DF00D);
    check("lim_err", i4.m0_err_o, 0);
    check("lim_pulse", i4.o_timeout, 0);
    tick();
    i4.s_ack_i = 0;
    #1;
    check("lim_after_err", i4.m0_err_o, 0);
    check("lim_after_pulse", i4.o_timeout, 0);
    check("lim_after_grant", i4.o_grant, 2'b01);
    i4.m0_cyc_i = 0; i4.m0_stb_i = 0;
    tick();
    tick();

    // reset asserted while master 0 is mid-strobe
    drive(0, 1, 1, 0, 32'h99, 0);
    tick();
    check("rm_s_cyc", i8.s_cyc_o, 1);
    i8.s_ack_i = 1; i8.s_dat_i = 32'hFFFF0000;
    wb_rst_i = 1;
    #1;
    check("rm_cyc", i8.s_cyc_o, 0);
    check("rm_stb", i8.s_stb_o, 0);
    check("rm_grant", i8.o_grant, 0);
    check("rm_ack", i8.m0_ack_o, 0);
    check("rm_err", i8.m0_err_o, 0);
    check("rm_dat", i8.m0_dat_o, 0);
    drive(0, 0, 0, 0, 0, 0);
    i8.s_ack_i = 0;
    tick();
    wb_rst_i = 0;
    drive(1, 1, 1, 0, 32'h123, 0);
    tick();
    check("rm_m1_grant", i8.o_grant, 2'b10);
    drive(1, 0, 0, 0, 0, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
